// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop input synchroniser,
// 3-sample majority vote around mid-bit, optional parity, 1 or 2 stop bits,
// and parity/framing/break reporting.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx_serial  asynchronous serial line, idle high
//   rx_dv      one-cycle pulse, frame complete (out_data and flags valid)
//   rx_active  high while a frame is being received
//   out_data   received word, LSB first on the line, held between frames
//   parity_err parity mismatch in the last frame
//   frame_err  a stop-bit sample was 0 in the last frame
//   break_det  last frame had all data bits 0 and a framing error
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic                 rx_dv,
    output logic                 rx_active,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned MID   = (CLKS_PER_BIT - 1) / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 sync1, rx_s;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [1:0]           smp, smp_n;
    logic                 par_flag, par_n;
    logic                 frm_flag, frm_n;
    logic                 stop_idx, stop_n;
    logic                 dv_n, active_n, perr_n, ferr_n, brk_n, frm_now;
    logic [DATA_BITS-1:0] data_n;

    logic bit_end, at_lo, at_mid, at_dec, maj;

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign at_lo   = (cnt == CNT_W'(MID - 1));
    assign at_mid  = (cnt == CNT_W'(MID));
    assign at_dec  = (cnt == CNT_W'(MID + 1));
    // Majority of the two stored samples and the live sample at MID+1.
    assign maj     = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    // State and datapath registers; synchroniser resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            smp        <= '0;
            par_flag   <= 1'b0;
            frm_flag   <= 1'b0;
            stop_idx   <= 1'b0;
            rx_dv      <= 1'b0;
            rx_active  <= 1'b0;
            out_data   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            sync1      <= rx_serial;
            rx_s       <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            smp        <= smp_n;
            par_flag   <= par_n;
            frm_flag   <= frm_n;
            stop_idx   <= stop_n;
            rx_dv      <= dv_n;
            rx_active  <= active_n;
            out_data   <= data_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            break_det  <= brk_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_end ? '0 : cnt + 1'b1;
        idx_n    = idx;
        shift_n  = shift;
        smp_n    = smp;
        par_n    = par_flag;
        frm_n    = frm_flag;
        stop_n   = stop_idx;
        dv_n     = 1'b0;
        active_n = rx_active;
        data_n   = out_data;
        perr_n   = parity_err;
        ferr_n   = frame_err;
        brk_n    = break_det;
        frm_now  = frm_flag | ~maj;

        if (at_lo)  smp_n[0] = rx_s;
        if (at_mid) smp_n[1] = rx_s;

        case (state)
            IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                stop_n = 1'b0;
                par_n  = 1'b0;
                frm_n  = 1'b0;
                if (!rx_s) begin
                    // The detecting cycle is cnt=0 of the start bit.
                    state_n  = START;
                    active_n = 1'b1;
                    cnt_n    = CNT_W'(1);
                end
            end
            START: begin
                if (at_dec && maj) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                    cnt_n    = '0;
                end else if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (at_dec) shift_n[idx] = maj;
                if (bit_end) begin
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_dec && (maj != ((^shift) ^ 1'(PARITY_ODD)))) par_n = 1'b1;
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (at_dec) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        // Leave early at the last decision point for resync.
                        state_n  = IDLE;
                        cnt_n    = '0;
                        active_n = 1'b0;
                        dv_n     = 1'b1;
                        data_n   = shift;
                        perr_n   = par_flag;
                        ferr_n   = frm_now;
                        brk_n    = (shift == '0) & frm_now;
                    end else begin
                        frm_n = frm_now;
                    end
                end
                if (bit_end) stop_n = 1'b1;
            end
            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                active_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7-data/2-stop)
// sharing clock and reset, each with its own serial line.
module tb_uart_rx_param;

    localparam int C   = 16;
    localparam int MID = (C - 1) / 2;
    // Pin edge to rx_dv for a 10-bit-time frame: 2 sync + 1 detect + 9 bits + MID+1.
    localparam int LAT  = 3 + 9 * C + MID + 1;
    localparam int LATP = 3 + 10 * C + MID + 1;

    logic clk = 1'b0;
    logic rst;
    logic rx0, rx1, rx2;

    logic       dv0, act0, pe0, fe0, bk0;
    logic [7:0] d0;
    logic       dv1, act1, pe1, fe1, bk1;
    logic [7:0] d1;
    logic       dv2, act2, pe2, fe2, bk2;
    logic [6:0] d2;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_t0  = 0;

    typedef struct {
        int         cyc;
        logic [8:0] data;
        logic       pe, fe, bk, act;
    } rec_t;
    rec_t q0[$], q1[$], q2[$];

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx_serial(rx0), .rx_dv(dv0), .rx_active(act0),
        .out_data(d0), .parity_err(pe0), .frame_err(fe0), .break_det(bk0));

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx_serial(rx1), .rx_dv(dv1), .rx_active(act1),
        .out_data(d1), .parity_err(pe1), .frame_err(fe1), .break_det(bk1));

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx_serial(rx2), .rx_dv(dv2), .rx_active(act2),
        .out_data(d2), .parity_err(pe2), .frame_err(fe2), .break_det(bk2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Capture every rx_dv pulse with its outputs, away from the active edge.
    always @(negedge clk) begin
        rec_t r;
        if (dv0) begin
            r.cyc = cyc; r.data = {1'b0, d0}; r.pe = pe0; r.fe = fe0; r.bk = bk0; r.act = act0;
            q0.push_back(r);
        end
        if (dv1) begin
            r.cyc = cyc; r.data = {1'b0, d1}; r.pe = pe1; r.fe = fe1; r.bk = bk1; r.act = act1;
            q1.push_back(r);
        end
        if (dv2) begin
            r.cyc = cyc; r.data = {2'b0, d2}; r.pe = pe2; r.fe = fe2; r.bk = bk2; r.act = act2;
            q2.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Drive bits[0..n-1] (start first), C cycles each, the last bit for
    // last_len cycles. Optional 1-cycle inversion at MID of glitch_bit, and
    // a reset pulse 3 cycles into abort_bit that ends the frame.
    task automatic send_frame(input int sel, input logic [15:0] bits, input int n,
                              input int last_len, input int glitch_bit, input int abort_bit);
        logic aborted;
        int   len;
        aborted = 1'b0;
        last_t0 = cyc;
        for (int i = 0; i < n; i++) begin
            if (aborted) break;
            set_line(sel, bits[i]);
            len = (i == n - 1) ? last_len : C;
            for (int c = 0; c < len; c++) begin
                if (i == glitch_bit && c == MID)     set_line(sel, ~bits[i]);
                if (i == glitch_bit && c == MID + 1) set_line(sel, bits[i]);
                if (i == abort_bit && c == 3) rst = 1'b1;
                if (i == abort_bit && c == 5) begin
                    rst     = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
        set_line(sel, 1'b1);
    endtask

    task automatic check_frame(input int sel, input string tag, input int ecnt,
                               input logic [8:0] ed, input logic epe, input logic efe,
                               input logic ebk, input int elat);
        rec_t r;
        int   sz;
        sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
        check({tag, " dv_count"}, 32'(sz), 32'(ecnt));
        if (sz > 0) begin
            r = (sel == 0) ? q0.pop_front() : (sel == 1) ? q1.pop_front() : q2.pop_front();
            check({tag, " data"},       32'(r.data), 32'(ed));
            check({tag, " parity_err"}, 32'(r.pe),   32'(epe));
            check({tag, " frame_err"},  32'(r.fe),   32'(efe));
            check({tag, " break_det"},  32'(r.bk),   32'(ebk));
            check({tag, " active@dv"},  32'(r.act),  32'(0));
            if (elat >= 0) check({tag, " latency"}, 32'(r.cyc - last_t0), 32'(elat));
        end
    endtask

    initial begin
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        idle(3);
        check("reset dv",        32'(dv0),  32'(0));
        check("reset active",    32'(act0), 32'(0));
        check("reset data",      32'(d0),   32'(0));
        check("reset flags",     32'({pe0, fe0, bk0}), 32'(0));
        rst = 1'b0;
        idle(5);
        check("post-reset idle", 32'({dv0, act0, dv1, act1, dv2, act2}), 32'(0));

        // 8N1, 0xA5, with exact latency
        send_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, C, -1, -1);
        idle(20);
        check_frame(0, "8n1 a5", 1, 9'h0A5, 1'b0, 1'b0, 1'b0, LAT);

        // False start: line low 3 cycles
        last_t0 = cyc;
        set_line(0, 1'b0);
        idle(3);
        set_line(0, 1'b1);
        idle(2);
        check("false start active", 32'(act0), 32'(1));
        idle(6);
        check("false start release", 32'(act0), 32'(0));
        idle(200);
        check("false start no dv", 32'(q0.size()), 32'(0));

        // Even parity: 0x03 has even weight, parity bit must be 0
        send_frame(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, C, -1, -1);
        idle(20);
        check_frame(1, "par bad", 1, 9'h003, 1'b1, 1'b0, 1'b0, LATP);
        send_frame(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, C, -1, -1);
        idle(20);
        check_frame(1, "par good", 1, 9'h003, 1'b0, 1'b0, 1'b0, LATP);

        // Low stop bit: break and plain framing error
        send_frame(0, 16'({1'b0, 8'h00, 1'b0}), 10, MID + 2, -1, -1);
        idle(30);
        check_frame(0, "break", 1, 9'h000, 1'b0, 1'b1, 1'b1, -1);
        send_frame(0, 16'({1'b0, 8'h5A, 1'b0}), 10, MID + 2, -1, -1);
        idle(30);
        check_frame(0, "frame 5a", 1, 9'h05A, 1'b0, 1'b1, 1'b0, -1);

        // Glitch at MID of data bit 3 is out-voted
        send_frame(0, 16'({1'b1, 8'hFF, 1'b0}), 10, C, 4, -1);
        idle(20);
        check_frame(0, "glitch ff", 1, 9'h0FF, 1'b0, 1'b0, 1'b0, -1);

        // Back-to-back frames
        send_frame(0, 16'({1'b1, 8'h12, 1'b0}), 10, C, -1, -1);
        send_frame(0, 16'({1'b1, 8'h34, 1'b0}), 10, C, -1, -1);
        idle(20);
        check_frame(0, "b2b 12", 2, 9'h012, 1'b0, 1'b0, 1'b0, -1);
        check_frame(0, "b2b 34", 1, 9'h034, 1'b0, 1'b0, 1'b0, -1);

        // 7 data bits, 2 stop bits
        send_frame(2, 16'({2'b11, 7'h55, 1'b0}), 10, C, -1, -1);
        idle(20);
        check_frame(2, "7n2 55", 1, 9'h055, 1'b0, 1'b0, 1'b0, LAT);

        // Reset during data bit 4 discards the frame
        send_frame(2, 16'({2'b11, 7'h2A, 1'b0}), 10, C, -1, 5);
        idle(3);
        check("abort data",   32'(d2),   32'(0));
        check("abort active", 32'(act2), 32'(0));
        check("abort flags",  32'({pe2, fe2, bk2}), 32'(0));
        idle(200);
        check("abort no dv",  32'(q2.size()), 32'(0));
        send_frame(2, 16'({2'b11, 7'h2A, 1'b0}), 10, C, -1, -1);
        idle(20);
        check_frame(2, "7n2 2a", 1, 9'h02A, 1'b0, 1'b0, 1'b0, LAT);

        check("stray dv u0", 32'(q0.size()), 32'(0));
        check("stray dv u1", 32'(q1.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It generalises the fixed 8N1 receiver with configurable data width, optional parity, one or two stop bits, and majority-vote mid-bit sampling. It adds an input synchroniser, parity/framing error reporting, break detection and an asynchronous reset. It sits between the serial pin and the byte-consuming logic (command decoder or RX FIFO), one instance per channel.

Parameters:
CLKS_PER_BIT, 217, clocks per bit period; legal range is 4 and up.
DATA_BITS, 8, data bits per frame; legal range is 5 to 9.
PARITY_EN, 0, 1 means a parity bit follows the data.
PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  in  1  system clock, all logic on its rising edge
rst  in  1  asynchronous, active-high reset
rx_serial  in  1  asynchronous serial line; idle is high
rx_dv  out  1  one-cycle pulse: frame complete; out_data and the error flags are valid
rx_active  out  1  high while a frame is being received
out_data  out  DATA_BITS  received word, LSB first on the line, held between frames
parity_err  out  1  parity mismatch in the last frame, updated with rx_dv
frame_err  out  1  a stop-bit sample was 0 in the last frame, updated with rx_dv
break_det  out  1  last frame had all data bits 0 and frame_err=1, updated with rx_dv

Behaviour:
- Reset values: rx_dv=0, rx_active=0, out_data=0, parity_err=0, frame_err=0, break_det=0. The state is IDLE, counters are 0, and both synchroniser flops are 1.
- Synchroniser: rx_serial passes through 2 flops to give rx_s. All sampling uses rx_s, so there is 2 cycles of input latency.
- Bit timer: cnt runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is clog2(CLKS_PER_BIT). MID=(CLKS_PER_BIT-1)/2.
- Sampling: rx_s is captured at cnt = MID-1, MID and MID+1. The bit value is the majority of the 3 samples, decided at cnt=MID+1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: cnt=0 and bit index=0. If rx_s=0, go to START and set rx_active=1 on the same edge; that cycle counts as cnt=0.
- START: at cnt=MID+1, a majority of 1 is a false start: return to IDLE, rx_active=0, no rx_dv. Otherwise continue to the bit boundary and enter DATA.
- DATA: the majority bit is written to shift position idx at MID+1. At the boundary, idx increments. After idx=DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: the majority bit is compared with the XOR of the data bits, inverted when PARITY_ODD=1. A mismatch sets an internal parity flag. Go to STOP at the boundary.
- STOP: a majority of 0 in any stop bit sets the internal frame flag.
  - With STOP_BITS=2, the first stop bit runs to its boundary before the second begins.
  - At MID+1 of the last stop bit, return to IDLE; the rest of that stop bit is not waited out, which allows early resync.
  - On the next cycle: rx_dv=1 for exactly 1 cycle, out_data/parity_err/frame_err/break_det are loaded, and rx_active=0.
- Total latency: rx_dv rises 1 cycle after the final-stop-bit decision point, plus 2 synchroniser cycles from the pin.
- If rx_s is low on return to IDLE (break or back-to-back frame), START is entered immediately. A continuous break therefore yields repeated frames, each with break_det=1.
- Error flags and out_data change only on an rx_dv cycle and hold otherwise. They are reported even on errored frames; the consumer decides whether to discard.
- No parity state is visited when PARITY_EN=0; parity_err stays 0.
- rst asserted mid-frame: immediate return to reset values, no rx_dv, the partial word is discarded. After release, the block waits in IDLE for the next falling edge of rx_s.
- Default state encoding recovers to IDLE.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 -> one rx_dv pulse, out_data=0xA5, all error flags 0, rx_active low in the rx_dv cycle.
- 8N1, line low for 3 cycles then high -> false start, no rx_dv, rx_active returns to 0 within MID+4 cycles of the edge.
- PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> rx_dv with parity_err=1, out_data=0x03. Then send 0x03 with parity bit 0 -> parity_err=0.
- 8N1, send 0x00 with the stop bit held low -> frame_err=1, break_det=1. Send 0x5A with a low stop bit -> frame_err=1, break_det=0.
- A 1-cycle inverted glitch at cnt=MID of data bit 3 in 0xFF -> the majority rejects it, out_data=0xFF. Two back-to-back frames, 0x12 then 0x34 -> two rx_dv pulses with the correct data.
- DATA_BITS=7, STOP_BITS=2, send 0x55 -> out_data=0x55, rx_dv at MID+1 of the second stop bit plus 1. Assert rst during data bit 4 -> outputs reset, no rx_dv; the next full frame is received correctly.
